// File: rtl/vc_switch_arbiter_pkg.sv
// vc_switch_arbiter_pkg: router-wide arbiter state encoding, defaults and index-width helper
package vc_switch_arbiter_pkg;
  typedef enum logic {S_IDLE, S_GRANT} state_t;
  localparam int NUM_VC_DEF = 4;
  localparam int MAX_CRED_DEF = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/vc_switch_arbiter_credit.sv
// vc_credit_counter: saturating per-VC downstream credit counter, resets full
module vc_credit_counter #(
  parameter int MAX_CRED = 4,
  parameter int CRED_W = 3
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              inc,
  input  logic              dec,
  output logic [CRED_W-1:0] cnt,
  output logic              nonzero,
  output logic              ovf,
  output logic              unf
);
  localparam logic [CRED_W-1:0] MAX = CRED_W'(MAX_CRED);
  logic [CRED_W-1:0] r_cnt;
  logic              w_full;
  assign w_full  = r_cnt == MAX;
  assign cnt     = r_cnt;
  assign nonzero = r_cnt != '0;
  assign ovf     = inc & w_full;
  assign unf     = dec & ~nonzero;
  // simultaneous inc and dec cancel; both ends saturate
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_cnt <= MAX;
    else if (inc & ~dec & ~w_full) r_cnt <= r_cnt + 1'b1;
    else if (dec & ~inc & nonzero) r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/vc_switch_arbiter.sv
// vc_switch_arbiter: packet-granular round-robin VC arbiter with per-VC credit tracking
module vc_switch_arbiter
  import vc_switch_arbiter_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int MAX_CRED = MAX_CRED_DEF,
  parameter int CRED_W = 3
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic [NUM_VC-1:0]         req,
  input  logic [NUM_VC-1:0]         tail,
  input  logic                      flit_sent,
  input  logic [NUM_VC-1:0]         credit_in,
  output logic [NUM_VC-1:0]         gnt,
  output logic [clog2(NUM_VC)-1:0]  gnt_id,
  output logic                      busy,
  output logic                      stall,
  output logic                      err
);
  localparam int IDX_W = clog2(NUM_VC);
  localparam logic [IDX_W:0] N = (IDX_W+1)'(NUM_VC);
  state_t              r_state;
  logic [NUM_VC-1:0]   r_gnt;
  logic [IDX_W-1:0]    r_gnt_id, r_ptr;
  logic                r_err;
  logic [NUM_VC-1:0]   w_nonzero, w_ovf, w_unf, w_dec, w_elig, w_rot;
  logic [CRED_W-1:0]   w_cnt [NUM_VC];
  logic [IDX_W-1:0]    w_off, w_win, w_nptr;
  logic [IDX_W:0]      w_wsum;
  logic                w_busy, w_rel;
  assign w_busy = r_state == S_GRANT;
  assign w_elig = req & w_nonzero;
  assign w_rel  = w_busy & flit_sent & tail[r_gnt_id];
  assign w_nptr = (r_gnt_id == IDX_W'(NUM_VC-1)) ? '0 : r_gnt_id + 1'b1;
  assign w_wsum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win  = IDX_W'((w_wsum >= N) ? w_wsum - N : w_wsum);
  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign busy   = w_busy;
  assign stall  = w_busy & (w_cnt[r_gnt_id] == '0);
  assign err    = r_err;
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [IDX_W:0] w_sum;
    assign w_sum    = {1'b0, r_ptr} + (IDX_W+1)'(v);
    assign w_rot[v] = w_elig[IDX_W'((w_sum >= N) ? w_sum - N : w_sum)];
    assign w_dec[v] = w_busy & flit_sent & (r_gnt_id == IDX_W'(v));
    vc_credit_counter #(.MAX_CRED(MAX_CRED), .CRED_W(CRED_W)) u_cred (
      .clk     (clk),
      .clr_n   (clr_n),
      .inc     (credit_in[v]),
      .dec     (w_dec[v]),
      .cnt     (w_cnt[v]),
      .nonzero (w_nonzero[v]),
      .ovf     (w_ovf[v]),
      .unf     (w_unf[v])
    );
  end
  // priority encoder on the ptr-rotated eligibility: lowest offset wins
  always_comb begin
    w_off = '0;
    for (int k = NUM_VC - 1; k >= 0; k--) if (w_rot[k]) w_off = IDX_W'(k);
  end
  // grant FSM: hold grant until a tail flit leaves, then force one idle cycle
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= r_err | (flit_sent & ~w_busy) | (|w_unf) | (|w_ovf);
      if (r_state == S_IDLE) begin
        if (|w_elig) begin
          r_state  <= S_GRANT;
          r_gnt    <= NUM_VC'(1) << w_win;
          r_gnt_id <= w_win;
        end
      end else if (w_rel) begin
        r_state <= S_IDLE;
        r_gnt   <= '0;
        r_ptr   <= w_nptr;
      end
    end
endmodule

// File: tb/tb_vc_switch_arbiter.sv
// tb_vc_switch_arbiter: directed scenarios plus randomized traffic against a packet-level model
module tb_vc_switch_arbiter;
  localparam int NV = 4;
  localparam int MC = 4;
  logic clk = 1'b0, clr_n = 1'b0;
  logic [NV-1:0] req = '0, tail = '0, credit_in = '0, gnt;
  logic flit_sent = 1'b0, busy, stall, err;
  logic [1:0] gnt_id;
  int n_cmp = 0, n_bad = 0;
  int m_cred [NV];
  bit m_busy, m_err;
  int m_id, m_ptr;

  vc_switch_arbiter dut (
    .clk(clk), .clr_n(clr_n), .req(req), .tail(tail), .flit_sent(flit_sent),
    .credit_in(credit_in), .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] m_vec();
    logic [3:0] g;
    logic s;
    g = m_busy ? (4'b0001 << m_id) : 4'b0000;
    s = m_busy && m_cred[m_id] == 0;
    return {g, 2'(m_id), m_busy, s, m_err};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NV; i++) m_cred[i] = MC;
    m_busy = 0; m_err = 0; m_id = 0; m_ptr = 0;
  endtask

  // one clock: model applies the arbitration and credit rules to this cycle's inputs
  task automatic tick();
    int oc [NV];
    bit ob;
    @(posedge clk);
    for (int i = 0; i < NV; i++) oc[i] = m_cred[i];
    ob = m_busy;
    if (flit_sent && (!ob || oc[m_id] == 0)) m_err = 1;
    for (int i = 0; i < NV; i++) begin
      bit dn;
      dn = ob && flit_sent && m_id == i;
      if (credit_in[i] && oc[i] == MC) m_err = 1;
      if (credit_in[i] && !dn) m_cred[i] = (oc[i] < MC) ? oc[i] + 1 : MC;
      else if (dn && !credit_in[i]) m_cred[i] = (oc[i] > 0) ? oc[i] - 1 : 0;
    end
    if (ob) begin
      if (flit_sent && tail[m_id]) begin
        m_busy = 0;
        m_ptr = (m_id + 1) % NV;
      end
    end else begin
      for (int k = 0; k < NV; k++) begin
        int j;
        j = (m_ptr + k) % NV;
        if (!m_busy && req[j] && oc[j] > 0) begin
          m_busy = 1;
          m_id = j;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_n = 1'b0; req = '0; tail = '0; flit_sent = 1'b0; credit_in = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({gnt, gnt_id, busy, stall, err} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset: got %b want %b", {gnt, gnt_id, busy, stall, err}, 9'b0);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      n_bad++;
      $display("FAIL single_grant: gnt %b id %0d want 0010 id 1", gnt, gnt_id);
    end
    req = 4'b0000; flit_sent = 1'b1;
    tick();
    tick();
    tail = 4'b0010;
    tick();
    flit_sent = 1'b0; tail = '0;
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_release: gnt %b busy %b want 0000 0", gnt, busy);
    end
    req = 4'b0010;
    tick();
    flit_sent = 1'b1;
    tick();
    flit_sent = 1'b0;
    n_cmp++;
    if (stall !== 1'b1 || gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL single_one_credit_left: stall %b gnt %b want 1 0010", stall, gnt);
    end
    credit_in = 4'b0010;
    tick();
    credit_in = '0; flit_sent = 1'b1; tail = 4'b0010;
    tick();
    flit_sent = 1'b0; tail = '0; req = '0;
    n_cmp++;
    if ({gnt, gnt_id, busy, stall, err} !== m_vec()) begin
      n_bad++;
      $display("FAIL single_end: got %b want %b", {gnt, gnt_id, busy, stall, err}, m_vec());
    end
  endtask

  task automatic test_fairness();
    int ord [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111; tail = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      tick();
      n_cmp++;
      if (gnt !== (4'b0001 << ord[p]) || gnt_id !== 2'(ord[p])) begin
        n_bad++;
        $display("FAIL fair_grant%0d: gnt %b id %0d want vc %0d", p, gnt, gnt_id, ord[p]);
      end
      flit_sent = 1'b1;
      tick();
      flit_sent = 1'b0;
      n_cmp++;
      if (gnt !== 4'b0000) begin
        n_bad++;
        $display("FAIL fair_gap%0d: gnt %b want 0000", p, gnt);
      end
    end
    req = '0; tail = '0;
  endtask

  task automatic test_starvation();
    do_reset();
    req = 4'b0001;
    tick();
    flit_sent = 1'b1;
    for (int f = 0; f < 4; f++) tick();
    flit_sent = 1'b0;
    n_cmp++;
    if (stall !== 1'b1 || gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL starve_stall: stall %b gnt %b want 1 0001", stall, gnt);
    end
    credit_in = 4'b0001;
    tick();
    credit_in = '0;
    n_cmp++;
    if (stall !== 1'b0 || gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL starve_credit: stall %b gnt %b want 0 0001", stall, gnt);
    end
    flit_sent = 1'b1; tail = 4'b0001;
    tick();
    flit_sent = 1'b0; tail = '0; req = '0;
    n_cmp++;
    if (gnt !== 4'b0000 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL starve_tail: gnt %b err %b want 0000 0", gnt, err);
    end
  endtask

  task automatic test_skip();
    do_reset();
    req = 4'b0100;
    tick();
    flit_sent = 1'b1;
    for (int f = 0; f < 4; f++) begin
      tail = (f == 3) ? 4'b0100 : 4'b0000;
      tick();
    end
    flit_sent = 1'b0; tail = '0; req = 4'b0010;
    tick();
    flit_sent = 1'b1; tail = 4'b0010;
    tick();
    flit_sent = 1'b0; tail = '0; req = 4'b0110;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      n_bad++;
      $display("FAIL skip_zero_credit: gnt %b id %0d want 0010 id 1", gnt, gnt_id);
    end
    req = '0;
  endtask

  task automatic test_errors();
    do_reset();
    flit_sent = 1'b1;
    tick();
    flit_sent = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_idle_flit: err %b want 1", err);
    end
    do_reset();
    credit_in = 4'b0001;
    tick();
    credit_in = '0;
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_credit_ovf: err %b want 1", err);
    end
    req = 4'b0001;
    tick();
    flit_sent = 1'b1;
    for (int f = 0; f < 3; f++) tick();
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL err_cred_3_sent: stall %b want 0", stall);
    end
    tick();
    flit_sent = 1'b0;
    n_cmp++;
    if (stall !== 1'b1 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_cred_stays_max: stall %b err %b want 1 1", stall, err);
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    tick();
    flit_sent = 1'b1;
    tick();
    flit_sent = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_async: gnt %b busy %b want 0000 0", gnt, busy);
    end
    m_reset();
    @(negedge clk);
    clr_n = 1'b1; req = 4'b0110;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || {gnt, gnt_id, busy, stall, err} !== m_vec()) begin
      n_bad++;
      $display("FAIL reset_mid_regrant: got %b want %b", {gnt, gnt_id, busy, stall, err}, m_vec());
    end
    flit_sent = 1'b1;
    for (int f = 0; f < 4; f++) tick();
    flit_sent = 1'b0;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_cred_full: stall %b want 1", stall);
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom);
      tail = 4'($urandom) & 4'($urandom);
      flit_sent = m_busy && m_cred[m_id] > 0 && $urandom_range(0, 3) != 0;
      for (int i = 0; i < NV; i++)
        credit_in[i] = m_cred[i] < MC && $urandom_range(0, 3) == 0;
      if (c % 97 == 96) flit_sent = 1'($urandom);
      tick();
      n_cmp++;
      if ({gnt, gnt_id, busy, stall, err} !== m_vec()) begin
        n_bad++;
        $display("FAIL random_c%0d: got %b want %b", c, {gnt, gnt_id, busy, stall, err}, m_vec());
      end
    end
    req = '0; tail = '0; flit_sent = 1'b0; credit_in = '0;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_starvation();
    test_skip();
    test_errors();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
